// File: rtl/ft64_fetchq_xn_pkg.sv
// Shared FT64 fetch-queue definitions: panic codes, NOP encoding and queue limits.
package ft64_fetchq_xn_pkg;

  typedef enum logic [3:0] {
    PANIC_NONE            = 4'h0,
    PANIC_FETCHBUFBEQ     = 4'h1,
    PANIC_INVALIDISLOT    = 4'h2,
    PANIC_MEMORYRACE      = 4'h3,
    PANIC_IDENTICALDRAMS  = 4'h4,
    PANIC_OVERRUN         = 4'h5,
    PANIC_HALTINSTRUCTION = 4'h6,
    PANIC_INVALIDMEMOP    = 4'h7,
    PANIC_INVALIDFBSTATE  = 4'h9,
    PANIC_INVALIDIQSTATE  = 4'hA,
    PANIC_BRANCHBACK      = 4'hB,
    PANIC_BADTARGETID     = 4'hC,
    PANIC_COMMIT          = 4'hD
  } panic_e;

  localparam logic [47:0] NOP_INSN        = 48'h00000000001C;
  localparam int unsigned FETCHQ_MAXDEPTH = 16;
  localparam int unsigned INSN_W          = 48;
  localparam int unsigned ILEN_W          = 3;

  // Packed entry layout: {insn, insln, pc}, pc in the low bits.
  function automatic int unsigned entry_w(input int unsigned amsb);
    return INSN_W + ILEN_W + amsb + 1;
  endfunction

endpackage

// File: rtl/ft64_fetchq_xn_ram.sv
// Fetch-queue storage: DEPTH entries, one synchronous write port, DEQW async read ports.
module ft64_fetchq_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 83,
  parameter int DEQW  = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEQW*AW-1:0]    raddr,
  output logic [DEQW*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < DEQW; k++)
      rdata[k*WIDTH +: WIDTH] = mem[raddr[k*AW +: AW]];
  end

endmodule

// File: rtl/ft64_fetchq_xn.sv
// FT64 fetch queue: circular instruction buffer with redirect/flush and head-relative slots.
// Optional performance counters enabled by defining FETCHQ_PERFCNT_EN.
module ft64_fetchq_xn
  import ft64_fetchq_xn_pkg::*;
#(
  parameter int             AMSB  = 31,
  parameter int             DEPTH = 4,
  parameter int             DEQW  = 2,
  parameter logic [AMSB:0]  RSTPC = 32'hFFFC0100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [47:0]                insn_i,
  input  logic [2:0]                 insln_i,
  input  logic                       phit_i,
  input  logic                       freeze_pc_i,
  input  logic                       branchmiss_i,
  input  logic [AMSB:0]              misspc_i,
  input  logic [DEQW-1:0]            take_i,
  input  logic [DEQW*(AMSB+1)-1:0]   tgt_i,
  input  logic [1:0]                 deq_cnt_i,
  output logic [AMSB:0]              pc_o,
  output logic [DEQW-1:0]            fb_v_o,
  output logic [DEQW*48-1:0]         fb_instr_o,
  output logic [DEQW*(AMSB+1)-1:0]   fb_pc_o,
  output logic [DEQW*3-1:0]          fb_insln_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [3:0]                 panic_o,
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                flush_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = AMSB + 1;
  localparam int EW = entry_w(AMSB);

  logic [AW-1:0]      head, tail;
  logic [CW-1:0]      count;
  logic [AMSB:0]      pc;
  panic_e             panic;

  logic [DEQW-1:0]    fb_v;
  logic [DEQW*AW-1:0] raddr;
  logic [DEQW*EW-1:0] rdata;

  logic               redirect;
  logic [CW-1:0]      keep_cnt;
  logic [AMSB:0]      tgt_sel;
  logic [CW-1:0]      lim, dreq, d;
  logic               deq_bad;
  logic               enq;

  ft64_fetchq_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .DEQW  (DEQW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (enq),
    .waddr (tail),
    .wdata ({insn_i, insln_i, pc}),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    fb_v       = '0;
    raddr      = '0;
    fb_instr_o = '0;
    fb_insln_o = '0;
    fb_pc_o    = '0;
    for (int unsigned k = 0; k < DEQW; k++) begin
      fb_v[k]                 = count > CW'(k);
      raddr[k*AW +: AW]       = head + AW'(k);
      fb_pc_o[k*PW +: PW]     = rdata[k*EW +: PW];
      fb_insln_o[k*3 +: 3]    = rdata[k*EW + PW +: 3];
      fb_instr_o[k*48 +: 48]  = rdata[k*EW + PW + 3 +: 48];
    end
  end

  // Oldest valid slot carrying a taken branch wins the redirect.
  always_comb begin
    redirect = 1'b0;
    keep_cnt = '0;
    tgt_sel  = '0;
    for (int unsigned k = 0; k < DEQW; k++) begin
      if (!redirect && fb_v[k] && take_i[k]) begin
        redirect = 1'b1;
        keep_cnt = CW'(k + 1);
        tgt_sel  = tgt_i[k*PW +: PW];
      end
    end
  end

  always_comb begin
    lim     = (count < CW'(DEQW)) ? count : CW'(DEQW);
    dreq    = CW'(deq_cnt_i);
    deq_bad = dreq > lim;
    d       = deq_bad ? lim : dreq;
    // Entries past the redirect slot are gone, so they cannot also be dequeued.
    if (redirect && d > keep_cnt) d = keep_cnt;
    enq = phit_i && !freeze_pc_i && (count < CW'(DEPTH)) && !branchmiss_i && !redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RSTPC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      panic <= PANIC_NONE;
    end else if (branchmiss_i) begin
      pc    <= misspc_i;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head <= head + AW'(d);
      if (deq_bad) panic <= PANIC_INVALIDIQSTATE;
      if (redirect) begin
        tail  <= head + AW'(keep_cnt);
        count <= keep_cnt - d;
        pc    <= tgt_sel;
      end else begin
        if (enq) begin
          tail <= tail + AW'(1);
          pc   <= pc + PW'(insln_i);
        end
        count <= count + CW'(enq) - d;
      end
    end
  end

`ifdef FETCHQ_PERFCNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (phit_i && count == CW'(DEPTH) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if ((branchmiss_i || redirect) && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign pc_o    = pc;
  assign fb_v_o  = fb_v;
  assign count_o = count;
  assign panic_o = panic;

endmodule

// File: tb/tb_ft64_fetchq_xn.sv
// Directed self-checking bench for ft64_fetchq_xn (default parameters).
module tb_ft64_fetchq_xn;

  logic         clk = 1'b0;
  logic         rst;
  logic [47:0]  insn_i;
  logic [2:0]   insln_i;
  logic         phit_i, freeze_pc_i, branchmiss_i;
  logic [31:0]  misspc_i;
  logic [1:0]   take_i;
  logic [63:0]  tgt_i;
  logic [1:0]   deq_cnt_i;
  logic [31:0]  pc_o;
  logic [1:0]   fb_v_o;
  logic [95:0]  fb_instr_o;
  logic [63:0]  fb_pc_o;
  logic [5:0]   fb_insln_o;
  logic [2:0]   count_o;
  logic [3:0]   panic_o;
  logic [31:0]  stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

`ifdef FETCHQ_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  ft64_fetchq_xn #(
    .AMSB  (31),
    .DEPTH (4),
    .DEQW  (2),
    .RSTPC (32'hFFFC0100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .insn_i       (insn_i),
    .insln_i      (insln_i),
    .phit_i       (phit_i),
    .freeze_pc_i  (freeze_pc_i),
    .branchmiss_i (branchmiss_i),
    .misspc_i     (misspc_i),
    .take_i       (take_i),
    .tgt_i        (tgt_i),
    .deq_cnt_i    (deq_cnt_i),
    .pc_o         (pc_o),
    .fb_v_o       (fb_v_o),
    .fb_instr_o   (fb_instr_o),
    .fb_pc_o      (fb_pc_o),
    .fb_insln_o   (fb_insln_o),
    .count_o      (count_o),
    .panic_o      (panic_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; phit_i = 1'b0; freeze_pc_i = 1'b0; branchmiss_i = 1'b0;
    misspc_i = '0; take_i = '0; tgt_i = '0; deq_cnt_i = '0;
    insln_i = 3'd4; insn_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; phit_i = 1'b1; branchmiss_i = 1'b1; misspc_i = 32'h0000_5000; deq_cnt_i = 2'd2;
    step();
    checks++; if (pc_o !== 32'hFFFC0100) begin errors++; $display("FAIL reset_pc got %h exp FFFC0100", pc_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (fb_v_o !== 2'b00) begin errors++; $display("FAIL reset_fbv got %b exp 00", fb_v_o); end
    checks++; if (panic_o !== 4'h0) begin errors++; $display("FAIL reset_panic got %h exp 0", panic_o); end
    checks++; if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o); end
    idle();
  endtask

  task automatic test_fill();
    phit_i = 1'b1; insln_i = 3'd4;
    insn_i = {16'hC0DE, pc_o};
    step();
    checks++; if (count_o !== 3'd1 || fb_v_o !== 2'b01) begin errors++; $display("FAIL latency got cnt %0d v %b exp 1 01", count_o, fb_v_o); end
    checks++; if (fb_pc_o[31:0] !== 32'hFFFC0100) begin errors++; $display("FAIL latency_pc got %h exp FFFC0100", fb_pc_o[31:0]); end
    for (int i = 0; i < 4; i++) begin
      insn_i = {16'hC0DE, pc_o};
      step();
    end
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count_o); end
    checks++; if (fb_pc_o !== {32'hFFFC0104, 32'hFFFC0100}) begin errors++; $display("FAIL fill_pcs got %h exp FFFC0104FFFC0100", fb_pc_o); end
    checks++; if (pc_o !== 32'hFFFC0110) begin errors++; $display("FAIL fill_pc_o got %h exp FFFC0110", pc_o); end
    checks++; if (fb_instr_o[47:0] !== 48'hC0DE_FFFC0100 || fb_insln_o !== 6'o44) begin errors++; $display("FAIL fill_slot0 got %h/%o exp C0DEFFFC0100/44", fb_instr_o[47:0], fb_insln_o); end
    checks++; if (fb_v_o !== 2'b11) begin errors++; $display("FAIL fill_fbv got %b exp 11", fb_v_o); end
    checks++; if (stall_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL fill_stall got %0d exp %0d", stall_cnt_o, PERF ? 1 : 0); end
  endtask

  task automatic test_full_deq();
    phit_i = 1'b1; deq_cnt_i = 2'd2; insn_i = {16'hC0DE, pc_o};
    step();
    deq_cnt_i = 2'd0;
    checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL fulldeq_count got %0d exp 2", count_o); end
    checks++; if (fb_pc_o !== {32'hFFFC010C, 32'hFFFC0108}) begin errors++; $display("FAIL fulldeq_pcs got %h exp FFFC010CFFFC0108", fb_pc_o); end
    checks++; if (pc_o !== 32'hFFFC0110) begin errors++; $display("FAIL fulldeq_pc_o got %h exp FFFC0110", pc_o); end
    checks++; if (stall_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL fulldeq_stall got %0d exp %0d", stall_cnt_o, PERF ? 2 : 0); end
    checks++; if (panic_o !== 4'h0) begin errors++; $display("FAIL fulldeq_panic got %h exp 0", panic_o); end
  endtask

  task automatic test_redirect();
    phit_i = 1'b1; insn_i = {16'hC0DE, pc_o};
    step();
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL redir_pre_count got %0d exp 3", count_o); end
    take_i = 2'b01; tgt_i = {32'h0000_4000, 32'h0000_2000}; insn_i = {16'hC0DE, pc_o};
    step();
    take_i = 2'b00;
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL redir_count got %0d exp 1", count_o); end
    checks++; if (pc_o !== 32'h0000_2000) begin errors++; $display("FAIL redir_pc_o got %h exp 00002000", pc_o); end
    checks++; if (fb_v_o !== 2'b01 || fb_pc_o[31:0] !== 32'hFFFC0108) begin errors++; $display("FAIL redir_slot0 got %b %h exp 01 FFFC0108", fb_v_o, fb_pc_o[31:0]); end
    checks++; if (flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin errors++; $display("FAIL redir_flush got %0d exp %0d", flush_cnt_o, PERF ? 1 : 0); end
    insn_i = {16'hC0DE, pc_o};
    step();
    checks++; if (count_o !== 3'd2 || fb_pc_o[63:32] !== 32'h0000_2000) begin errors++; $display("FAIL redir_refill got %0d %h exp 2 00002000", count_o, fb_pc_o[63:32]); end
    checks++; if (pc_o !== 32'h0000_2004) begin errors++; $display("FAIL redir_refill_pc got %h exp 00002004", pc_o); end
  endtask

  task automatic test_branchmiss();
    branchmiss_i = 1'b1; misspc_i = 32'h0000_3000; take_i = 2'b11;
    tgt_i = {32'h0000_4000, 32'h0000_2000}; deq_cnt_i = 2'd1; phit_i = 1'b1;
    step();
    idle();
    checks++; if (count_o !== 3'd0 || fb_v_o !== 2'b00) begin errors++; $display("FAIL bmiss_count got %0d %b exp 0 00", count_o, fb_v_o); end
    checks++; if (pc_o !== 32'h0000_3000) begin errors++; $display("FAIL bmiss_pc got %h exp 00003000", pc_o); end
    checks++; if (panic_o !== 4'h0) begin errors++; $display("FAIL bmiss_panic got %h exp 0", panic_o); end
    checks++; if (flush_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin errors++; $display("FAIL bmiss_flush got %0d exp %0d", flush_cnt_o, PERF ? 2 : 0); end
  endtask

  task automatic test_panic();
    phit_i = 1'b1; insln_i = 3'd2; insn_i = {16'hBEEF, pc_o};
    step();
    checks++; if (count_o !== 3'd1 || pc_o !== 32'h0000_3002 || fb_insln_o[2:0] !== 3'd2) begin errors++; $display("FAIL panic_pre got %0d %h %0d exp 1 00003002 2", count_o, pc_o, fb_insln_o[2:0]); end
    phit_i = 1'b0; deq_cnt_i = 2'd2;
    step();
    deq_cnt_i = 2'd0;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL panic_count got %0d exp 0", count_o); end
    checks++; if (panic_o !== 4'hA) begin errors++; $display("FAIL panic_code got %h exp A", panic_o); end
    step(); step();
    checks++; if (panic_o !== 4'hA) begin errors++; $display("FAIL panic_sticky got %h exp A", panic_o); end
    do_reset();
    checks++; if (panic_o !== 4'h0) begin errors++; $display("FAIL panic_clear got %h exp 0", panic_o); end
    deq_cnt_i = 2'd1;
    step();
    deq_cnt_i = 2'd0;
    checks++; if (panic_o !== 4'hA || count_o !== 3'd0 || fb_v_o !== 2'b00) begin errors++; $display("FAIL panic_empty got %h %0d %b exp A 0 00", panic_o, count_o, fb_v_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    phit_i = 1'b1; insln_i = 3'd4;
    for (int i = 0; i < 3; i++) begin
      insn_i = {16'hC0DE, pc_o};
      step();
    end
    phit_i = 1'b0; deq_cnt_i = 2'd2;
    step();
    checks++; if (count_o !== 3'd1 || fb_pc_o[31:0] !== 32'hFFFC0108) begin errors++; $display("FAIL wrap_setup got %0d %h exp 1 FFFC0108", count_o, fb_pc_o[31:0]); end
    deq_cnt_i = 2'd1;
    step();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d exp 0", count_o); end
    deq_cnt_i = 2'd0; phit_i = 1'b1;
    insn_i = {16'hC0DE, pc_o};
    step();
    insn_i = {16'hC0DE, pc_o};
    step();
    checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL wrap_count2 got %0d exp 2", count_o); end
    checks++; if (fb_pc_o !== {32'hFFFC0110, 32'hFFFC010C}) begin errors++; $display("FAIL wrap_read got %h exp FFFC0110FFFC010C", fb_pc_o); end
    deq_cnt_i = 2'd2; insn_i = {16'hC0DE, pc_o};
    step();
    deq_cnt_i = 2'd0; phit_i = 1'b0;
    checks++; if (count_o !== 3'd1 || fb_v_o !== 2'b01) begin errors++; $display("FAIL wrap_final_count got %0d %b exp 1 01", count_o, fb_v_o); end
    checks++; if (fb_pc_o[31:0] !== 32'hFFFC0114) begin errors++; $display("FAIL wrap_final_pc got %h exp FFFC0114", fb_pc_o[31:0]); end
    checks++; if (pc_o !== 32'hFFFC0118 || panic_o !== 4'h0) begin errors++; $display("FAIL wrap_pc_o got %h %h exp FFFC0118 0", pc_o, panic_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin errors++; $display("FAIL wrap_stall got %0d exp 0", stall_cnt_o); end
  endtask

  task automatic test_freeze();
    phit_i = 1'b1; freeze_pc_i = 1'b1; insn_i = {16'hC0DE, pc_o};
    step();
    idle();
    checks++; if (count_o !== 3'd1 || pc_o !== 32'hFFFC0118) begin errors++; $display("FAIL freeze got %0d %h exp 1 FFFC0118", count_o, pc_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_full_deq();
    test_redirect();
    test_branchmiss();
    test_panic();
    test_wrap();
    test_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft64_fetchq_xn.md
FT64_FETCHQ_XN -- requirements
Module: ft64_fetchq_xn

Interface
REQ-001 SHALL have parameter AMSB, default 31: msb of all pc/address fields.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries; power of 2, 2..16.
REQ-003 SHALL have parameter DEQW, default 2: output slots, 1..2.
REQ-004 SHALL have parameter RSTPC, default 32'hFFFC0100: fetch pc after reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 insn_i  in  48  expanded instruction from the I-cache/expander at pc_o.
REQ-008 insln_i  in  3  byte length of insn_i (2, 4 or 6).
REQ-009 phit_i  in  1  insn_i valid (cache hit).
REQ-010 freeze_pc_i  in  1  hold pc_o; no enqueue.
REQ-011 branchmiss_i  in  1  flush everything; misspc_i  in  AMSB+1  restart pc.
REQ-012 take_i  in  DEQW  slot k holds a predicted/unconditional taken branch.
REQ-013 tgt_i  in  DEQW*(AMSB+1)  slot k target, slot k in bits [k*(AMSB+1)+:AMSB+1].
REQ-014 deq_cnt_i  in  2  number of slots queued by the issue logic this cycle.
REQ-015 pc_o  out  AMSB+1  next fetch address.
REQ-016 fb_v_o  out  DEQW; fb_instr_o  out  DEQW*48; fb_pc_o  out  DEQW*(AMSB+1); fb_insln_o  out  DEQW*3: head-relative slots.
REQ-017 count_o  out  $clog2(DEPTH)+1  valid entries; panic_o  out  4  sticky error code.

Function
REQ-018 Circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH; count separate, 0..DEPTH.
REQ-019 Slot k outputs: fb_v_o[k]=(count>k); instr/pc/insln from entry head+k (mod DEPTH); combinational from registers.
REQ-020 Enqueue when phit_i & ~freeze_pc_i & count<DEPTH & ~branchmiss_i & ~redirect: write {insn_i, insln_i, pc_o} at tail, tail+1, pc_o<=pc_o+insln_i; full test uses pre-dequeue count (no deq-to-enq path).
REQ-021 Dequeue: head+=d, count-=d, d=deq_cnt_i; if deq_cnt_i>min(count,DEQW), d is clamped to min(count,DEQW) and panic_o<=PANIC_INVALIDIQSTATE.
REQ-022 Redirect: k = lowest slot with fb_v_o[k]&take_i[k]; tail<=head+k+1, entries younger than k discarded, pc_o<=tgt_i slot k, no enqueue that cycle; dequeue of the same cycle applies.
REQ-023 branchmiss_i overrides all: head=tail=count=0, pc_o<=misspc_i, panic_o unchanged, deq_cnt_i ignored.
REQ-024 Simultaneous enqueue+dequeue: count += 1-d; tail/head wrap independently.
REQ-025 Empty queue: fb_v_o all 0, deq_cnt_i>0 raises panic per REQ-021.
REQ-026 Latency: instruction enqueued in cycle n visible in slot output in cycle n+1.

Reset
REQ-027 On rst: pc_o=RSTPC, head=tail=count=0, fb_v_o=0, panic_o=PANIC_NONE, counters 0; storage contents not reset.
REQ-028 rst dominates branchmiss_i, redirect, enqueue and dequeue in the same cycle.

Configuration
REQ-029 Macro FETCHQ_PERFCNT_EN defined: outputs stall_cnt_o (32, increments each cycle phit_i&count==DEPTH) and flush_cnt_o (32, increments on branchmiss_i or redirect), saturating at all-ones.
REQ-030 Macro undefined: both ports present, tied to 0, no counter flops.

Structure
REQ-031 PANIC_* codes and NOP_INSN come from the shared FT64 defines/package; add FETCHQ_MAXDEPTH=16 there.
REQ-032 One sub-module ft64_fetchq_ram (DEPTH x (48+3+AMSB+1), 1 write, DEQW async reads).

Verification
REQ-033 Reset, phit_i=1, insln 4 for 5 cycles, no deq -> count 4, slot pcs FFFC0100/0104, pc_o=FFFC0110, 5th not enqueued.
REQ-034 Full queue, deq_cnt_i=2 with phit_i=1 -> count 2 next cycle, head advances 2, no enqueue that cycle.
REQ-035 count=3, take_i=2'b01, tgt=0000_2000 -> count 1 next cycle, pc_o=00002000.
REQ-036 branchmiss_i with misspc_i=00003000 while take_i=2'b11, deq_cnt_i=1 -> count 0, pc_o=00003000.
REQ-037 count=1, deq_cnt_i=2 -> count 0, panic_o=PANIC_INVALIDIQSTATE, sticky until rst.
REQ-038 Head at DEPTH-1, 3 enqueues/2 dequeues -> correct pcs across wrap; with FETCHQ_PERFCNT_EN stall_cnt_o counts full cycles.
